// File: rtl/queue_pop_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// queue_pop_arbiter_pkg
// FSM state encoding and the default requester count shared by the arbiter.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package queue_pop_arbiter_pkg;

  localparam int NUM_REQ_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    RESP = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/queue_pop_arbiter_rr_grant.sv
// -----------------------------------------------------------------------------
// queue_pop_arbiter_rr_grant
// Combinational grant selection: round-robin from a pointer, or lowest-index
// fixed priority when QUEUE_POP_ARB_FIXED_PRIO_EN is defined.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module queue_pop_arbiter_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  always_comb begin
    int idx;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef QUEUE_POP_ARB_FIXED_PRIO_EN
      idx = k;
`else
      // Search begins at the pointer and wraps past NUM_REQ-1 back to 0.
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
`endif
      if (!grant_vld && req[idx]) begin
        grant_vld = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/queue_pop_arbiter.sv
// -----------------------------------------------------------------------------
// queue_pop_arbiter
// Shares the queue read port between NUM_REQ requesters; one pop per grant,
// data returned with a one-cycle ack. Option: QUEUE_POP_ARB_FIXED_PRIO_EN.
// Revision: 1.0
// -----------------------------------------------------------------------------
`default_nettype none

`ifndef QUEUE_DEPTH
`define QUEUE_DEPTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module queue_pop_arbiter
  import queue_pop_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEFAULT,
  parameter int QUEUE_DEPTH = `QUEUE_DEPTH,
  parameter int DATA_WIDTH  = `DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*QUEUE_DEPTH-1:0] req_sel,
  output logic [NUM_REQ-1:0]             ack,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_err,
  output logic                           busy,
  output logic                           q_pop,
  output logic [QUEUE_DEPTH-1:0]         q_rd_sel,
  input  logic [DATA_WIDTH-1:0]          q_data_out,
  input  logic                           q_empty
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    busy_q, busy_d;
  logic                    q_pop_q, q_pop_d;
  logic [QUEUE_DEPTH-1:0]  q_rd_sel_q, q_rd_sel_d;

  logic [IDX_W-1:0]        arb_idx;
  logic                    arb_vld;
  logic [QUEUE_DEPTH-1:0]  arb_sel;
  logic [QUEUE_DEPTH-1:0]  sel_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign sel_arr[gi] = req_sel[gi*QUEUE_DEPTH +: QUEUE_DEPTH];
    end
  endgenerate

  assign arb_sel = sel_arr[arb_idx];

`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0] ptr_q, ptr_d;
`endif

  queue_pop_arbiter_rr_grant #(
    .NUM_REQ   (NUM_REQ),
    .IDX_W     (IDX_W)
  ) u_rr_grant (
    .req       (req),
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
    .ptr       (ptr_q),
`endif
    .grant_idx (arb_idx),
    .grant_vld (arb_vld)
  );

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    ack_d       = '0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    q_pop_d     = 1'b0;
    q_rd_sel_d  = '0;
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          grant_idx_d = arb_idx;
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
          ptr_d = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
`endif
          if (!q_empty && $onehot(arb_sel)) begin
            state_d    = POP;
            q_pop_d    = 1'b1;
            q_rd_sel_d = arb_sel;
          end else begin
            // Rejected: answer straight away without touching the queue.
            state_d        = RESP;
            rsp_err_d      = 1'b1;
            rsp_data_d     = '0;
            ack_d[arb_idx] = 1'b1;
          end
        end
      end
      POP: begin
        state_d = CAPT;
      end
      CAPT: begin
        state_d            = RESP;
        rsp_data_d         = q_data_out;
        rsp_err_d          = 1'b0;
        ack_d[grant_idx_q] = 1'b1;
      end
      RESP: begin
        state_d    = IDLE;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_idx_q <= '0;
      ack_q       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      q_pop_q     <= 1'b0;
      q_rd_sel_q  <= '0;
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
      ptr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_idx_q <= grant_idx_d;
      ack_q       <= ack_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      q_pop_q     <= q_pop_d;
      q_rd_sel_q  <= q_rd_sel_d;
`ifndef QUEUE_POP_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign ack      = ack_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = busy_q;
  assign q_pop    = q_pop_q;
  assign q_rd_sel = q_rd_sel_q;

endmodule

`default_nettype wire
